// File: rtl/traffic_phase_ctr.sv
// Round-robin traffic-light sequencer (GREEN -> YELLOW -> ALLRED) with manual change, pedestrian walk and night flash.
// Every output is a register that updates on the clk edge after the state or tick event; no backpressure.
module traffic_phase_ctr #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int NUM_DIR     = 2,
  parameter int GREEN_S     = 10,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 1,
  parameter int MIN_GREEN_S = 4,
  parameter int WALK_S      = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               change,
  input  logic [NUM_DIR-1:0] ped_req,
  input  logic               night,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] walk,
  output logic [1:0]         phase,
  output logic [7:0]         sec_left
);

  localparam int              PW        = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]   TICK_MAX  = PW'(TICK_CYCLES - 1);
  localparam logic [1:0]      LAST_P    = 2'(NUM_DIR - 1);
  localparam logic [7:0]      GREEN_T   = 8'(GREEN_S);
  localparam logic [7:0]      YELLOW_T  = 8'(YELLOW_S);
  localparam logic [7:0]      ALLRED_T  = 8'(ALLRED_S);
  localparam logic [7:0]      GUARD_MAX = 8'(GREEN_S - MIN_GREEN_S);
  localparam logic [7:0]      WALK_END  = 8'(GREEN_S - WALK_S);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

  state_t              state;
  logic [PW-1:0]       presc;
  logic [NUM_DIR-1:0]  pend;
  logic                chg_pend;
  logic                change_d;

  logic                tick;
  logic                last_sec;
  logic [7:0]          sec_dec;
  logic                guard_met;
  logic                change_rise;
  logic [1:0]          next_p;
  logic [NUM_DIR-1:0]  pend_in;
  logic [NUM_DIR-1:0]  next_mask;
  logic [NUM_DIR-1:0]  cur_mask;

  function automatic logic [NUM_DIR-1:0] dir_mask(input logic [1:0] idx);
    dir_mask = NUM_DIR'(1) << idx;
  endfunction

  assign tick        = (presc == TICK_MAX);
  assign last_sec    = tick && (sec_left == 8'd1);
  assign sec_dec     = sec_left - 8'd1;
  // Elapsed seconds are judged after this cycle's tick, so a change can end green on the exact second boundary.
  assign guard_met   = (tick ? sec_dec : sec_left) <= GUARD_MAX;
  assign change_rise = change && !change_d;
  assign next_p      = (phase == LAST_P) ? 2'd0 : phase + 2'd1;
  assign pend_in     = pend | ped_req;
  assign next_mask   = dir_mask(next_p);
  assign cur_mask    = dir_mask(phase);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_ALLRED;
      presc    <= '0;
      pend     <= '0;
      chg_pend <= 1'b0;
      change_d <= 1'b0;
      red      <= '1;
      yellow   <= '0;
      green    <= '0;
      walk     <= '0;
      phase    <= LAST_P;
      sec_left <= ALLRED_T;
    end else begin
      change_d <= change;
      pend     <= pend_in;
      presc    <= tick ? '0 : presc + PW'(1);
      if (tick) sec_left <= sec_dec;
      case (state)
        S_GREEN: begin
          if (change_rise) chg_pend <= 1'b1;
          if (tick && sec_dec == WALK_END) walk <= '0;
          if (night || (chg_pend && guard_met) || last_sec) begin
            state    <= S_YELLOW;
            presc    <= '0;
            sec_left <= YELLOW_T;
            chg_pend <= 1'b0;
            green    <= '0;
            walk     <= '0;
            yellow   <= cur_mask;
          end
        end
        S_YELLOW: begin
          if (last_sec) begin
            state    <= S_ALLRED;
            presc    <= '0;
            sec_left <= ALLRED_T;
            yellow   <= '0;
            red      <= '1;
          end
        end
        S_ALLRED: begin
          if (last_sec) begin
            presc <= '0;
            if (night) begin
              state    <= S_FLASH;
              phase    <= LAST_P;
              sec_left <= 8'd0;
              red      <= '0;
              yellow   <= '1;
            end else begin
              // A request arriving on the entry cycle is served now and consumed.
              state    <= S_GREEN;
              phase    <= next_p;
              sec_left <= GREEN_T;
              red      <= ~next_mask;
              green    <= next_mask;
              walk     <= (|(pend_in & next_mask)) ? next_mask : '0;
              pend     <= pend_in & ~next_mask;
            end
          end
        end
        S_FLASH: begin
          sec_left <= 8'd0;
          if (!night) begin
            state    <= S_ALLRED;
            presc    <= '0;
            sec_left <= ALLRED_T;
            red      <= '1;
            yellow   <= '0;
          end else if (tick) begin
            yellow <= ~yellow;
          end
        end
        default: state <= S_ALLRED;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctr.sv
// Bench for traffic_phase_ctr: directed timing scenarios plus random inputs, all checked against a
// cycle-count model that derives lamps and countdown from time spent in each state.
module tb_traffic_phase_ctr;

  localparam int TK = 4, ND = 3, GS = 5, YS = 2, AS = 1, MG = 2, WS = 3;
  localparam int M_G = 0, M_Y = 1, M_A = 2, M_F = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          change = 1'b0;
  logic [ND-1:0] ped_req = '0;
  logic          night = 1'b0;
  logic [ND-1:0] red, yellow, green, walk;
  logic [1:0]    phase;
  logic [7:0]    sec_left;

  int n_vec = 0;
  int n_err = 0;

  traffic_phase_ctr #(
    .TICK_CYCLES(TK), .NUM_DIR(ND), .GREEN_S(GS), .YELLOW_S(YS),
    .ALLRED_S(AS), .MIN_GREEN_S(MG), .WALK_S(WS)
  ) dut (
    .clk(clk), .reset(reset), .change(change), .ped_req(ped_req), .night(night),
    .red(red), .yellow(yellow), .green(green), .walk(walk),
    .phase(phase), .sec_left(sec_left)
  );

  always #5 clk = ~clk;

  // Reference model: state, served direction, cycles spent in the state.
  int          m_st, m_p, m_t;
  bit [ND-1:0] m_pend;
  bit          m_chg, m_prev_chg, m_walk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_s(input int st);
    case (st)
      M_G:     return GS;
      M_Y:     return YS;
      M_A:     return AS;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_A; m_p = ND - 1; m_t = 0;
    m_pend = '0; m_chg = 0; m_prev_chg = 0; m_walk = 0;
  endtask

  task automatic enter(input int st);
    m_st = st; m_t = 0; m_chg = 0;
  endtask

  task automatic model_tick();
    bit rise, done;
    rise = change && !m_prev_chg;
    m_prev_chg = change;
    m_pend |= ped_req;
    done = (m_t + 1 == dur_s(m_st) * TK);
    case (m_st)
      M_G: begin
        if (night || (m_chg && (m_t + 1) / TK >= MG) || done) enter(M_Y);
        else begin
          m_t++;
          if (rise) m_chg = 1;
        end
      end
      M_Y: if (done) enter(M_A); else m_t++;
      M_A: begin
        if (!done) m_t++;
        else if (night) begin
          m_p = ND - 1;
          enter(M_F);
        end else begin
          m_p = (m_p + 1) % ND;
          m_walk = m_pend[m_p[1:0]];
          m_pend[m_p[1:0]] = 1'b0;
          enter(M_G);
        end
      end
      default: if (!night) enter(M_A); else m_t++;
    endcase
  endtask

  task automatic compare_all();
    logic [ND-1:0] one, e_r, e_y, e_g, e_w;
    int e_sec;
    one = 3'(1) << m_p;
    e_r = '0; e_y = '0; e_g = '0; e_w = '0; e_sec = 0;
    case (m_st)
      M_G: begin
        e_g = one; e_r = ~one; e_sec = GS - m_t / TK;
        if (m_walk && m_t < WS * TK) e_w = one;
      end
      M_Y: begin e_y = one; e_r = ~one; e_sec = YS - m_t / TK; end
      M_A: begin e_r = '1; e_sec = AS - m_t / TK; end
      default: e_y = ((m_t / TK) % 2 == 0) ? '1 : '0;
    endcase
    chk("red", 32'(red), 32'(e_r));
    chk("yellow", 32'(yellow), 32'(e_y));
    chk("green", 32'(green), 32'(e_g));
    chk("walk", 32'(walk), 32'(e_w));
    chk("phase", 32'(phase), 32'(m_p));
    chk("sec_left", 32'(sec_left), 32'(e_sec));
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset(); else model_tick();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [2:0] lamp(input int which);
    case (which)
      0:       return red;
      1:       return yellow;
      2:       return green;
      default: return walk;
    endcase
  endfunction

  task automatic measure(input int which, input logic [2:0] pat, output int n);
    n = 0;
    while (lamp(which) == pat && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic wait_for(input string tag, input int which, input logic [2:0] pat);
    int k = 0;
    while (lamp(which) != pat && k < 300) begin
      step();
      k++;
    end
    if (lamp(which) != pat) chk({tag, "_timeout"}, 32'(lamp(which)), 32'(pat));
  endtask

  task automatic idle_sequence(input string tag);
    int n;
    measure(0, 3'b111, n); chk({tag, "_red_first"}, n, 4);
    measure(2, 3'b001, n); chk({tag, "_green0"}, n, 20);
    measure(1, 3'b001, n); chk({tag, "_yellow0"}, n, 8);
    measure(0, 3'b111, n); chk({tag, "_allred"}, n, 4);
    chk({tag, "_green1"}, 32'(green), 32'(3'b010));
    chk({tag, "_phase1"}, 32'(phase), 32'd1);
    chk({tag, "_sec5"}, 32'(sec_left), 32'd5);
  endtask

  initial begin
    int n;
    model_reset();
    @(negedge clk);
    compare_all();
    step();
    step();
    reset = 1'b1;
    idle_sequence("idle");

    // Manual change one cycle into green: green ends after the 2 s guard.
    wait_for("chg_wait", 2, 3'b001);
    step();
    change = 1'b1;
    step();
    change = 1'b0;
    measure(2, 3'b001, n);
    chk("chg_green_len", n + 2, 8);
    chk("chg_yel_sec", 32'(sec_left), 32'd2);
    // Change during yellow is ignored.
    step();
    change = 1'b1;
    step();
    change = 1'b0;
    measure(1, 3'b001, n);
    chk("chg_in_yel_len", n + 2, 8);
    measure(0, 3'b111, n); chk("chg_allred", n, 4);
    measure(2, 3'b010, n); chk("chg_next_green", n, 20);

    // Pedestrian request for direction 2 raised during phase-0 green.
    wait_for("ped_wait", 2, 3'b001);
    step();
    ped_req = 3'b100;
    step();
    ped_req = '0;
    wait_for("ped_g2", 2, 3'b100);
    measure(3, 3'b100, n); chk("ped_walk_len", n, 12);
    begin
      int g;
      measure(2, 3'b100, g);
      chk("ped_green_len", n + g, 20);
    end
    wait_for("ped_g2_again", 2, 3'b100);
    chk("ped_cleared", 32'(walk), 32'd0);

    // Night mode raised mid-green of phase 1.
    wait_for("night_wait", 2, 3'b010);
    step(); step(); step();
    night = 1'b1;
    step();
    chk("night_yel", 32'(yellow), 32'(3'b010));
    measure(1, 3'b010, n); chk("night_yel_len", n, 8);
    measure(0, 3'b111, n); chk("night_allred", n, 4);
    chk("flash_on", 32'(yellow), 32'(3'b111));
    chk("flash_red", 32'(red), 32'd0);
    measure(1, 3'b111, n); chk("flash_on_len", n, 4);
    measure(1, 3'b000, n); chk("flash_off_len", n, 4);
    night = 1'b0;
    step();
    chk("unflash_red", 32'(red), 32'(3'b111));
    measure(0, 3'b111, n); chk("unflash_allred", n, 4);
    chk("unflash_green0", 32'(green), 32'(3'b001));

    // Asynchronous reset in the middle of yellow.
    wait_for("rst_wait", 1, 3'b001);
    step();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_red", 32'(red), 32'(3'b111));
    chk("rst_yellow", 32'(yellow), 32'd0);
    step();
    step();
    reset = 1'b1;
    idle_sequence("rerun");

    // Random traffic: change, pedestrian, night and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      change  = ($urandom_range(0, 5) == 0);
      ped_req = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : '0;
      if ($urandom_range(0, 119) == 0) night = ~night;
      if ($urandom_range(0, 899) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      step();
    end
    night = 1'b0;
    change = 1'b0;
    ped_req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
